uart_tx_serializer: RTL and testbench

//   Byte-to-line UART transmitter: accepts one byte per en/busy handshake and shifts it out as an
//   8N1-style frame (start, LSB-first data, optional parity, stop) on uart_txp. It sits directly

---
 rtl/uart_tx_serializer.sv | 199 +++++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//
// Byte-to-line UART transmitter. It accepts one byte per tx_en / tx_busy
// handshake and shifts it out as a start / LSB-first data / optional parity /
// stop frame on uart_txp. The handshake is designed to sit directly behind a
// producer that registers its enable from !tx_busy. That producer holds
// tx_en high for one extra cycle after acceptance, and this block ignores
// that extra cycle.
//
// Parameters
//   CLK_FREQ   input clock frequency in Hz
//   BAUD       line rate in bit/s. One bit lasts round(CLK_FREQ/BAUD) clocks.
//   DATA_BITS  data bits per frame, 5..8. tx_data[7:DATA_BITS] is not sent.
//   PARITY     0 none, 1 odd, 2 even. Computed over the transmitted data bits.
//   STOP_BITS  1 or 2
//
// Ports
//   clk       in   system clock
//   rst       in   synchronous reset, active-high
//   tx_data   in   byte to send; sampled only on the accept edge
//   tx_en     in   send request; accepted on a clock edge while idle
//   tx_busy   out  high from the cycle after accept until the last stop bit ends
//   tx_done   out  one-cycle pulse on the cycle tx_busy falls
//   uart_txp  out  serial line, idle high
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int CLK_FREQ  = 27_000_000,
  parameter int BAUD      = 115_200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_en,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       uart_txp
);

  // Bit period in clocks, rounded to nearest.
  localparam int CLKS_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // -------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // -------------------------------------------------------------------------
  if (CLKS_PER_BIT < 2) begin : g_chk_clks
    $error("uart_tx_serializer: CLKS_PER_BIT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_chk_data_bits
    $error("uart_tx_serializer: DATA_BITS must be in 5..8");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_chk_parity
    $error("uart_tx_serializer: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop_bits
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end

  // Parity over the DATA_BITS low bits only. Odd parity makes the total
  // number of ones odd, and even parity makes it even.
  function automatic logic calc_parity(input logic [7:0] d);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < DATA_BITS) begin
        p = p ^ d[i];
      end
    end
    return (PARITY == 1) ? ~p : p;
  endfunction

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic             r_par;
  logic             r_txp;
  logic             r_busy;
  logic             r_done;

  logic w_accept;
  logic w_bit_end;
  logic w_shift_now;

  // tx_en is ignored outside IDLE, which covers the held-high echo cycle
  // from a registered-enable upstream.
  assign w_accept    = (r_state == S_IDLE) && tx_en;
  assign w_bit_end   = (r_cnt == CNT_LAST);
  assign w_shift_now = w_bit_end && ((r_state == S_START) || (r_state == S_DATA));

  // -------------------------------------------------------------------------
  // Data path: the shift register and the parity bit (no reset needed)
  // -------------------------------------------------------------------------
  // r_shift[0] always holds the next data bit to drive. It is consumed and
  // shifted at the end of the start bit and at the end of each data bit.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shift <= tx_data;
      r_par   <= calc_parity(tx_data);
    end else if (w_shift_now) begin
      r_shift <= r_shift >> 1;
    end
  end

  // -------------------------------------------------------------------------
  // Control: FSM, baud counter, bit index and registered line outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_txp   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        r_txp  <= 1'b1;
        r_busy <= 1'b0;
        r_cnt  <= '0;
        r_idx  <= '0;
        if (tx_en) begin
          r_state <= S_START;
          r_busy  <= 1'b1;
          r_txp   <= 1'b0;
        end
      end else if (!w_bit_end) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        // Bit boundary: restart the counter and choose the next bit.
        r_cnt <= '0;
        case (r_state)
          S_START: begin
            r_state <= S_DATA;
            r_idx   <= '0;
            r_txp   <= r_shift[0];
          end
          S_DATA: begin
            if (r_idx == DATA_LAST) begin
              r_idx <= '0;
              if (PARITY != 0) begin
                r_state <= S_PARITY;
                r_txp   <= r_par;
              end else begin
                r_state <= S_STOP;
                r_txp   <= 1'b1;
              end
            end else begin
              r_idx <= r_idx + 3'd1;
              r_txp <= r_shift[0];
            end
          end
          S_PARITY: begin
            r_state <= S_STOP;
            r_idx   <= '0;
            r_txp   <= 1'b1;
          end
          S_STOP: begin
            // r_idx counts the stop bits already sent.
            if (r_idx == STOP_LAST) begin
              r_state <= S_IDLE;
              r_idx   <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_txp   <= 1'b1;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tx_busy  = r_busy;
  assign tx_done  = r_done;
  assign uart_txp = r_txp;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Testbench for uart_tx_serializer. It runs four instances at 4 clocks/bit:
//   u0 8N1, u1 8E1, u2 8O1, u3 7N2.
module tb_uart_tx_serializer;

  localparam int C = 4;  // clocks per bit: CLK_FREQ=400, BAUD=100

  typedef bit bitq_t[$];

  typedef struct {
    int         unit;
    logic [7:0] data;
    int         exp_len;
    logic       exp_par;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       en   [4];
  logic [7:0] data [4];
  logic       busy [4];
  logic       done [4];
  logic       txp  [4];

  int n_chk  = 0;
  int n_fail = 0;

  uart_tx_serializer #(.CLK_FREQ(400), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .tx_data(data[0]), .tx_en(en[0]),
    .tx_busy(busy[0]), .tx_done(done[0]), .uart_txp(txp[0]));
  uart_tx_serializer #(.CLK_FREQ(400), .BAUD(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .tx_data(data[1]), .tx_en(en[1]),
    .tx_busy(busy[1]), .tx_done(done[1]), .uart_txp(txp[1]));
  uart_tx_serializer #(.CLK_FREQ(400), .BAUD(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .tx_data(data[2]), .tx_en(en[2]),
    .tx_busy(busy[2]), .tx_done(done[2]), .uart_txp(txp[2]));
  uart_tx_serializer #(.CLK_FREQ(400), .BAUD(100), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .tx_data(data[3]), .tx_en(en[3]),
    .tx_busy(busy[3]), .tx_done(done[3]), .uart_txp(txp[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit hit, required normal finish");
    $fatal(1, "watchdog");
  end

  function automatic int db_of(int u);  return (u == 3) ? 7 : 8;                    endfunction
  function automatic int par_of(int u); return (u == 1) ? 2 : ((u == 2) ? 1 : 0);  endfunction
  function automatic int sb_of(int u);  return (u == 3) ? 2 : 1;                    endfunction

  // Reference model. It builds the whole frame as a list of line levels,
  // one entry per bit.
  function automatic bitq_t frame_bits(int u, logic [7:0] b);
    bitq_t q;
    int ones;
    ones = 0;
    q.push_back(1'b0);
    for (int i = 0; i < db_of(u); i++) begin
      q.push_back(b[i]);
      ones += int'(b[i]);
    end
    if (par_of(u) == 2) q.push_back(bit'(ones % 2));
    if (par_of(u) == 1) q.push_back(bit'(1 - (ones % 2)));
    for (int i = 0; i < sb_of(u); i++) q.push_back(1'b1);
    return q;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Entered at the first negedge after the accept edge. Returns at the
  // negedge where busy has fallen, or after stop_after cycles.
  task automatic run_frame(input int u, input logic [7:0] b, input int stop_after,
                           input bit toggle, output int len, output logic pbit);
    bitq_t exp;
    int    f;
    exp  = frame_bits(u, b);
    f    = exp.size() * C;
    len  = 0;
    pbit = 1'bx;
    while (busy[u] === 1'b1 && len < f + 2 * C && len < stop_after) begin
      chk("txp_bit", txp[u], (len < f) ? exp[len / C] : 1'b1);
      chk("done_low_in_frame", done[u], 1'b0);
      if (par_of(u) != 0 && len == (1 + db_of(u)) * C + C / 2) pbit = txp[u];
      if (toggle) data[u] = 8'($urandom);
      len++;
      @(negedge clk);
    end
    if (len < stop_after) begin
      chk("frame_len", len, f);
      chk("done_pulse", done[u], 1'b1);
      chk("txp_idle_at_end", txp[u], 1'b1);
    end
  endtask

  task automatic send(input int u, input logic [7:0] b, input bit toggle,
                      output int len, output logic pbit);
    data[u] = b;
    en[u]   = 1'b1;
    @(negedge clk);
    en[u]   = 1'b0;
    run_frame(u, b, 100000, toggle, len, pbit);
  endtask

  task automatic idle_chk(input int u, input int n);
    repeat (n) begin
      @(negedge clk);
      chk("idle_busy", busy[u], 1'b0);
      chk("idle_done", done[u], 1'b0);
      chk("idle_txp", txp[u], 1'b1);
    end
  endtask

  // Line decoder on u0. It samples each bit mid-period after a falling edge.
  logic [7:0] rxq[$];
  int         mon_cnt = 0;
  logic [7:0] mon_byte;
  logic       mon_prev = 1'b1;
  always @(negedge clk) begin
    if (mon_cnt == 0) begin
      if (mon_prev === 1'b1 && txp[0] === 1'b0) mon_cnt = 1;
    end else begin
      if (mon_cnt % C == C / 2 && mon_cnt / C >= 1 && mon_cnt / C <= 8)
        mon_byte[mon_cnt / C - 1] = txp[0];
      if (mon_cnt == 9 * C + C / 2) begin
        if (txp[0] === 1'b1) rxq.push_back(mon_byte);
        mon_cnt = 0;
      end else begin
        mon_cnt++;
      end
    end
    mon_prev = txp[0];
  end

  // Upstream stage: a registered enable when !busy, and a pop on en && busy.
  task automatic upstream_test();
    logic [7:0] src[$];
    logic [7:0] want[3];
    bit nxt, pop;
    int cyc;
    src  = '{8'h48, 8'h69, 8'h0A};
    want = '{8'h48, 8'h69, 8'h0A};
    rxq.delete();
    mon_cnt = 0;
    en[0] = 1'b0;
    cyc = 0;
    while (cyc < 600 && !(src.size() == 0 && rxq.size() == 3 && busy[0] === 1'b0)) begin
      nxt = (src.size() > 0) && (busy[0] !== 1'b1);
      pop = (en[0] === 1'b1) && (busy[0] === 1'b1);
      @(posedge clk);
      #1;
      if (pop) void'(src.pop_front());
      en[0]   = nxt;
      data[0] = (src.size() > 0) ? src[0] : 8'h00;
      @(negedge clk);
      cyc++;
    end
    en[0] = 1'b0;
    chk("upstream_within_budget", (cyc < 600), 1'b1);
    chk("upstream_rx_count", rxq.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("upstream_rx_byte", (i < rxq.size()) ? rxq[i] : 8'hxx, want[i]);
  endtask

  vec_t tbl[8];

  initial begin
    int   len;
    logic pb;
    logic [7:0] b;
    int   gap;

    tbl[0] = '{0, 8'h55, 40, 1'b0};
    tbl[1] = '{1, 8'h07, 44, 1'b1};
    tbl[2] = '{2, 8'h07, 44, 1'b0};
    tbl[3] = '{1, 8'h00, 44, 1'b0};
    tbl[4] = '{2, 8'h00, 44, 1'b1};
    tbl[5] = '{1, 8'hFF, 44, 1'b0};
    tbl[6] = '{3, 8'hFF, 40, 1'b0};
    tbl[7] = '{3, 8'h80, 40, 1'b0};

    rst = 1'b1;
    for (int u = 0; u < 4; u++) begin
      en[u]   = 1'b0;
      data[u] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 4; u++) begin
      chk("reset_txp", txp[u], 1'b1);
      chk("reset_busy", busy[u], 1'b0);
      chk("reset_done", done[u], 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed table: frame length and parity bit are hand constants.
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].unit, tbl[i].data, 1'b0, len, pb);
      chk("tbl_frame_len", len, tbl[i].exp_len);
      if (par_of(tbl[i].unit) != 0) chk("tbl_parity_bit", pb, tbl[i].exp_par);
      idle_chk(tbl[i].unit, 1);
    end

    // tx_en held high for the whole frame, with tx_data churning: exactly one
    // frame goes out. The next byte is taken in the first idle cycle.
    data[0] = 8'hA3;
    en[0]   = 1'b1;
    @(negedge clk);
    run_frame(0, 8'hA3, 100000, 1'b1, len, pb);
    data[0] = 8'h5A;
    @(negedge clk);
    run_frame(0, 8'h5A, 100000, 1'b0, len, pb);
    en[0] = 1'b0;
    idle_chk(0, 2);

    // Reset mid-frame, with tx_en also high (rst must win).
    send_partial();
    rst   = 1'b1;
    en[0] = 1'b1;
    data[0] = 8'hEE;
    @(negedge clk);
    chk("midreset_txp", txp[0], 1'b1);
    chk("midreset_busy", busy[0], 1'b0);
    chk("midreset_done", done[0], 1'b0);
    rst   = 1'b0;
    en[0] = 1'b0;
    idle_chk(0, 2);
    send(0, 8'h3C, 1'b0, len, pb);
    idle_chk(0, 1);

    // Registered-enable upstream sending "Hi\n".
    idle_chk(0, 2 * C);
    upstream_test();
    idle_chk(0, 1);

    // Randomised bytes and idle gaps (gap 0 = back-to-back) on every unit.
    for (int u = 0; u < 4; u++) begin
      for (int n = 0; n < 8; n++) begin
        b = 8'($urandom);
        send(u, b, 1'b0, len, pb);
        gap = $urandom_range(0, 2);
        if (gap > 0) idle_chk(u, gap);
      end
      idle_chk(u, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Starts a 0x00 frame on u0 and stops after 17 checked cycles.
  task automatic send_partial();
    int   len;
    logic pb;
    data[0] = 8'h00;
    en[0]   = 1'b1;
    @(negedge clk);
    en[0]   = 1'b0;
    run_frame(0, 8'h00, 17, 1'b0, len, pb);
    chk("partial_reached_17", len, 17);
  endtask

endmodule
